// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared widths, opcode values, FSM state encoding, microcode
//   select encodings and the final-result helper for the ALU sequencer.
//   No ports; imported by alu_sequencer and alu_seq_microcode.
package alu_sequencer_pkg;

  localparam int WORD_SIZE      = 16;
  localparam int OPCODE_SIZE    = 4;
  localparam int SEQ_MAX_PASSES = 3;
  localparam int PASS_W         = $clog2(SEQ_MAX_PASSES);

  typedef logic [OPCODE_SIZE-1:0] opcode_t;
  typedef logic [WORD_SIZE-1:0]   word_t;
  typedef logic [PASS_W-1:0]      pass_t;

  // Opcode values. Anything from 4'd11 up is unsupported.
  localparam opcode_t OP_NOT  = 4'd0;
  localparam opcode_t OP_AND  = 4'd1;
  localparam opcode_t OP_OR   = 4'd2;
  localparam opcode_t OP_XOR  = 4'd3;
  localparam opcode_t OP_ADD  = 4'd4;
  localparam opcode_t OP_SUB  = 4'd5;
  localparam opcode_t OP_ADDI = 4'd6;
  localparam opcode_t OP_ANDI = 4'd7;
  localparam opcode_t OP_LT   = 4'd8;
  localparam opcode_t OP_EQ   = 4'd9;
  localparam opcode_t OP_COMP = 4'd10;

  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_ISSUE   = 2'd1,
    SEQ_CAPTURE = 2'd2,
    SEQ_RESP    = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {IN1_A = 2'd0, IN1_B = 2'd1, IN1_T = 2'd2} in1_sel_t;
  typedef enum logic [1:0] {IN2_B = 2'd0, IN2_T = 2'd1, IN2_ONE = 2'd2} in2_sel_t;

  // Turns the last pass's ALU output t into the architectural result.
  // LT decides on operand MSBs when they differ; otherwise the sign of a-b.
  function automatic word_t seq_result(input opcode_t op, input word_t a,
                                       input word_t b, input word_t t);
    word_t r;
    case (op)
      OP_LT:          r = (a[WORD_SIZE-1] != b[WORD_SIZE-1]) ?
                          WORD_SIZE'(b[WORD_SIZE-1]) : WORD_SIZE'(t[WORD_SIZE-1]);
      OP_EQ, OP_COMP: r = WORD_SIZE'(t == '0);
      default:        r = t;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_microcode.sv
// alu_seq_microcode: purely combinational decode of (op, pass) into one ALU pass.
//   Ports: i_op, i_pass in; o_alu_op, o_in1_sel, o_in2_sel, o_last, o_legal out.
//   No state, no handshake; o_legal=0 for unsupported opcodes.
module alu_seq_microcode
  import alu_sequencer_pkg::*;
(
  input  opcode_t  i_op,
  input  pass_t    i_pass,
  output opcode_t  o_alu_op,
  output in1_sel_t o_in1_sel,
  output in2_sel_t o_in2_sel,
  output logic     o_last,
  output logic     o_legal
);

  always_comb begin
    o_alu_op  = OP_NOT;
    o_in1_sel = IN1_A;
    o_in2_sel = IN2_B;
    o_last    = 1'b1;
    o_legal   = 1'b1;
    case (i_op)
      OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD: o_alu_op = i_op;
      // Immediate forms reuse the primitive gates; b already holds the immediate.
      OP_ADDI: o_alu_op = OP_ADD;
      OP_ANDI: o_alu_op = OP_AND;
      // a - b as a + (~b + 1); LT reads the sign of the same difference.
      OP_SUB, OP_LT: begin
        case (i_pass)
          2'd0: begin
            o_alu_op  = OP_NOT;
            o_in1_sel = IN1_B;
            o_in2_sel = IN2_B;
            o_last    = 1'b0;
          end
          2'd1: begin
            o_alu_op  = OP_ADD;
            o_in1_sel = IN1_T;
            o_in2_sel = IN2_ONE;
            o_last    = 1'b0;
          end
          default: begin
            o_alu_op  = OP_ADD;
            o_in1_sel = IN1_A;
            o_in2_sel = IN2_T;
          end
        endcase
      end
      OP_EQ, OP_COMP: o_alu_op = OP_XOR;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one request at a time through the gate-level ALU as
//   1 or 3 primitive passes. Latency accept->resp_valid: 3 cycles single-pass,
//   7 cycles SUB/LT, 1 cycle illegal. Response held until resp_ready; req_ready
//   only in IDLE. Ports: clock/reset, req_* (valid/ready), resp_* (valid/ready),
//   alu_enable/alu_opcode/alu_in1/alu_in2 out, alu_out in.
//   Optional: ALU_SEQ_STATS_EN adds stat_ops / stat_passes counters.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OPCODE_SIZE-1:0] req_opcode,
  input  logic [WORD_SIZE-1:0]   req_a,
  input  logic [WORD_SIZE-1:0]   req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WORD_SIZE-1:0]   resp_data,
  output logic                   resp_illegal,
  output logic                   alu_enable,
  output logic [OPCODE_SIZE-1:0] alu_opcode,
  output logic [WORD_SIZE-1:0]   alu_in1,
  output logic [WORD_SIZE-1:0]   alu_in2,
`ifdef ALU_SEQ_STATS_EN
  output logic [31:0]            stat_ops,
  output logic [31:0]            stat_passes,
`endif
  input  logic [WORD_SIZE-1:0]   alu_out
);

  seq_state_t r_state;
  opcode_t    r_op;
  word_t      r_a, r_b;
  pass_t      r_pass;
  logic       r_last;
  logic       r_resp_valid, r_resp_illegal, r_alu_enable;
  word_t      r_resp_data, r_alu_in1, r_alu_in2;
  opcode_t    r_alu_opcode;

  // Next pass to issue: from the live request in IDLE, else from latched state.
  // In CAPTURE, alu_out is the t that the next pass consumes.
  logic     w_idle;
  opcode_t  w_nx_op;
  pass_t    w_nx_pass;
  word_t    w_nx_a, w_nx_b, w_nx_in1, w_nx_in2, w_result;
  opcode_t  w_mc_alu_op;
  in1_sel_t w_mc_in1_sel;
  in2_sel_t w_mc_in2_sel;
  logic     w_mc_last, w_mc_legal;

  assign w_idle    = (r_state == SEQ_IDLE);
  assign w_nx_op   = w_idle ? req_opcode : r_op;
  assign w_nx_pass = w_idle ? '0 : r_pass + 2'd1;
  assign w_nx_a    = w_idle ? req_a : r_a;
  assign w_nx_b    = w_idle ? req_b : r_b;

  alu_seq_microcode u_microcode (
    .i_op      (w_nx_op),
    .i_pass    (w_nx_pass),
    .o_alu_op  (w_mc_alu_op),
    .o_in1_sel (w_mc_in1_sel),
    .o_in2_sel (w_mc_in2_sel),
    .o_last    (w_mc_last),
    .o_legal   (w_mc_legal)
  );

  always_comb begin
    w_nx_in1 = w_nx_a;
    case (w_mc_in1_sel)
      IN1_B:   w_nx_in1 = w_nx_b;
      IN1_T:   w_nx_in1 = alu_out;
      default: w_nx_in1 = w_nx_a;
    endcase
    w_nx_in2 = w_nx_b;
    case (w_mc_in2_sel)
      IN2_T:   w_nx_in2 = alu_out;
      IN2_ONE: w_nx_in2 = WORD_SIZE'(1);
      default: w_nx_in2 = w_nx_b;
    endcase
  end

  assign w_result = seq_result(r_op, r_a, r_b, alu_out);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= SEQ_IDLE;
      r_op           <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_pass         <= '0;
      r_last         <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_illegal <= 1'b0;
      r_resp_data    <= '0;
      r_alu_enable   <= 1'b0;
      r_alu_opcode   <= '0;
      r_alu_in1      <= '0;
      r_alu_in2      <= '0;
    end else begin
      // Enable is a single-cycle pulse; CAPTURE always sits low between passes.
      r_alu_enable <= 1'b0;
      case (r_state)
        SEQ_IDLE: begin
          if (req_valid) begin
            r_op   <= req_opcode;
            r_a    <= req_a;
            r_b    <= req_b;
            r_pass <= '0;
            if (w_mc_legal) begin
              r_alu_enable <= 1'b1;
              r_alu_opcode <= w_mc_alu_op;
              r_alu_in1    <= w_nx_in1;
              r_alu_in2    <= w_nx_in2;
              r_last       <= w_mc_last;
              r_state      <= SEQ_ISSUE;
            end else begin
              r_resp_valid   <= 1'b1;
              r_resp_illegal <= 1'b1;
              r_resp_data    <= '0;
              r_state        <= SEQ_RESP;
            end
          end
        end
        SEQ_ISSUE: r_state <= SEQ_CAPTURE;
        SEQ_CAPTURE: begin
          if (r_last) begin
            r_resp_valid   <= 1'b1;
            r_resp_illegal <= 1'b0;
            r_resp_data    <= w_result;
            r_state        <= SEQ_RESP;
          end else begin
            r_pass       <= w_nx_pass;
            r_alu_enable <= 1'b1;
            r_alu_opcode <= w_mc_alu_op;
            r_alu_in1    <= w_nx_in1;
            r_alu_in2    <= w_nx_in2;
            r_last       <= w_mc_last;
            r_state      <= SEQ_ISSUE;
          end
        end
        SEQ_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= SEQ_IDLE;
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

  assign req_ready    = w_idle && !reset;
  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign resp_illegal = r_resp_illegal;
  assign alu_enable   = r_alu_enable;
  assign alu_opcode   = r_alu_opcode;
  assign alu_in1      = r_alu_in1;
  assign alu_in2      = r_alu_in2;

`ifdef ALU_SEQ_STATS_EN
  logic [31:0] r_stat_ops, r_stat_passes;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_ops    <= '0;
      r_stat_passes <= '0;
    end else begin
      if (r_state == SEQ_RESP && resp_ready) r_stat_ops <= r_stat_ops + 32'd1;
      if (r_state == SEQ_ISSUE) r_stat_passes <= r_stat_passes + 32'd1;
    end
  end

  assign stat_ops    = r_stat_ops;
  assign stat_passes = r_stat_passes;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against a behavioural ALU.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_illegal;
  opcode_t     req_opcode, alu_opcode;
  logic [15:0] req_a, req_b, resp_data, alu_in1, alu_in2;
  logic        alu_enable;
  logic [15:0] alu_out = '0;
`ifdef ALU_SEQ_STATS_EN
  logic [31:0] stat_ops, stat_passes;
  int          exp_ops = 0, exp_passes = 0;
`endif

  always #5 clock = ~clock;

  alu_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_illegal (resp_illegal),
    .alu_enable   (alu_enable),
    .alu_opcode   (alu_opcode),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
`ifdef ALU_SEQ_STATS_EN
    .stat_ops     (stat_ops),
    .stat_passes  (stat_passes),
`endif
    .alu_out      (alu_out)
  );

  // Behavioural stand-in for the gate-level ALU: registered, primitives only.
  always @(posedge clock) begin
    if (alu_enable) begin
      case (alu_opcode)
        OP_NOT:  alu_out <= ~alu_in1;
        OP_AND:  alu_out <= alu_in1 & alu_in2;
        OP_OR:   alu_out <= alu_in1 | alu_in2;
        OP_XOR:  alu_out <= alu_in1 ^ alu_in2;
        OP_ADD:  alu_out <= alu_in1 + alu_in2;
        default: alu_out <= 16'h0000;
      endcase
    end
  end

  int      n_vec = 0;
  int      n_err = 0;
  opcode_t seen_ops [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Issue one request with resp_ready high; check latency, result and pulse count.
  task automatic run_op(input string tag, input opcode_t op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_d,
                        input logic exp_ill, input int exp_lat, input int exp_pulses);
    int   lat;
    int   pulses;
    logic prev;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    lat    = 1;
    pulses = 0;
    prev   = 1'b0;
    while (!resp_valid && lat < 20) begin
      if (alu_enable && !prev) begin
        if (pulses < 4) seen_ops[pulses] = alu_opcode;
        pulses++;
      end
      prev = alu_enable;
      tick;
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".data"}, resp_data, exp_d);
    chk({tag, ".illegal"}, resp_illegal, exp_ill);
    chk({tag, ".pulses"}, pulses, exp_pulses);
    chk({tag, ".req_ready_busy"}, req_ready, 1'b0);
    tick;
    chk({tag, ".resp_dropped"}, resp_valid, 1'b0);
    chk({tag, ".req_ready_next"}, req_ready, 1'b1);
`ifdef ALU_SEQ_STATS_EN
    exp_ops++;
    exp_passes += exp_pulses;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    tick;
    tick;
    chk("rst.req_ready", req_ready, 1'b0);
    chk("rst.resp_valid", resp_valid, 1'b0);
    chk("rst.resp_illegal", resp_illegal, 1'b0);
    chk("rst.resp_data", resp_data, 16'h0000);
    chk("rst.alu_enable", alu_enable, 1'b0);
    chk("rst.alu_opcode", alu_opcode, 4'h0);
    chk("rst.alu_in1", alu_in1, 16'h0000);
    chk("rst.alu_in2", alu_in2, 16'h0000);
    reset = 1'b0;
    #1;
    chk("idle.req_ready", req_ready, 1'b1);

    run_op("add",    OP_ADD,  16'h1234, 16'h0FFF, 16'h2233, 1'b0, 3, 1);
    run_op("sub",    OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 1'b0, 7, 3);
    chk("sub.op0", seen_ops[0], OP_NOT);
    chk("sub.op1", seen_ops[1], OP_ADD);
    chk("sub.op2", seen_ops[2], OP_ADD);
    run_op("sub_wrap", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 7, 3);
    run_op("lt1",    OP_LT,   16'h0001, 16'hFFFF, 16'h0001, 1'b0, 7, 3);
    run_op("lt2",    OP_LT,   16'h8000, 16'h7FFF, 16'h0000, 1'b0, 7, 3);
    run_op("lt3",    OP_LT,   16'h7FFF, 16'h8000, 16'h0001, 1'b0, 7, 3);
    run_op("lt4",    OP_LT,   16'h1234, 16'h1234, 16'h0000, 1'b0, 7, 3);
    run_op("eq",     OP_EQ,   16'hABCD, 16'hABCD, 16'h0001, 1'b0, 3, 1);
    run_op("comp",   OP_COMP, 16'hABCD, 16'hABCC, 16'h0000, 1'b0, 3, 1);
    run_op("not",    OP_NOT,  16'h00FF, 16'h0000, 16'hFF00, 1'b0, 3, 1);
    run_op("and",    OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 3, 1);
    run_op("or",     OP_OR,   16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 3, 1);
    run_op("xor",    OP_XOR,  16'hFFFF, 16'h1234, 16'hEDCB, 1'b0, 3, 1);
    run_op("addi",   OP_ADDI, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 3, 1);
    run_op("andi",   OP_ANDI, 16'h1234, 16'h00FF, 16'h0034, 1'b0, 3, 1);

    // Backpressure: response must hold for 5 cycles with resp_ready low.
    req_opcode = OP_ADD;
    req_a      = 16'h0101;
    req_b      = 16'h0202;
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("bp.latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp.resp_valid", resp_valid, 1'b1);
      chk("bp.resp_data", resp_data, 16'h0303);
      chk("bp.req_ready", req_ready, 1'b0);
      tick;
    end
    resp_ready = 1'b1;
    tick;
    chk("bp.released", resp_valid, 1'b0);
`ifdef ALU_SEQ_STATS_EN
    exp_ops++;
    exp_passes++;
`endif

    run_op("illegal", 4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1, 0);

`ifdef ALU_SEQ_STATS_EN
    chk("stats.ops", stat_ops, exp_ops);
    chk("stats.passes", stat_passes, exp_passes);
`endif

    // Reset while SUB pass 1 is on the ALU.
    req_opcode = OP_SUB;
    req_a      = 16'h0005;
    req_b      = 16'h0007;
    req_valid  = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk("midrst.pass1_enable", alu_enable, 1'b1);
    chk("midrst.pass1_opcode", alu_opcode, OP_ADD);
    reset = 1'b1;
    tick;
    chk("midrst.alu_enable", alu_enable, 1'b0);
    chk("midrst.resp_valid", resp_valid, 1'b0);
    chk("midrst.req_ready", req_ready, 1'b0);
    chk("midrst.alu_opcode", alu_opcode, 4'h0);
`ifdef ALU_SEQ_STATS_EN
    chk("midrst.stat_ops", stat_ops, 32'd0);
    chk("midrst.stat_passes", stat_passes, 32'd0);
`endif
    reset = 1'b0;
    #1;
    chk("midrst.idle", req_ready, 1'b1);
    for (int i = 0; i < 8; i++) tick;
    chk("midrst.no_stale_resp", resp_valid, 1'b0);
    run_op("post_rst_add", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller between instruction decode and the gate-level `alu`. It accepts one operation at a time over a valid/ready handshake and sequences it through the ALU as one or more primitive passes (NOT, AND, OR, XOR, ADD). SUB, LT, EQ and COMP are built from those passes, so every gate they use appears in the gate counter's counts. It returns the result over a held valid/ready response channel.

## Interface
- `WORD_SIZE`, 16: datapath width, from `parameters.vh`.
- `OPCODE_SIZE`, from `parameters.vh`: opcode width.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_opcode` in OPCODE_SIZE: operation, using the `` `NOT ``/`` `AND ``/... macros.
- `req_a`, `req_b` in WORD_SIZE: operands. For ADDI/ANDI, `req_b` is the immediate, already extended.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer takes the result.
- `resp_data` out WORD_SIZE: result.
- `resp_illegal` out 1: opcode unsupported; `resp_data` is 0.
- `alu_enable` out 1: drives the ALU's `alu_enable`.
- `alu_opcode` out OPCODE_SIZE: drives the ALU's `opcode`.
- `alu_in1`, `alu_in2` out WORD_SIZE: drive the ALU's `input1` and `input2`.
- `alu_out` in WORD_SIZE: registered ALU result, valid one cycle after an enabled edge.

## Operation
- **States:** IDLE, ISSUE, CAPTURE, RESP.
- **IDLE:** `req_ready=1`. On `req_valid&&req_ready`, latch opcode, a and b; set pass=0.
  - Supported opcode: go to ISSUE.
  - Unsupported opcode: go to RESP with data 0 and `resp_illegal=1`. No ALU pass is made.
- **ISSUE:** `alu_enable=1` for exactly one cycle, with opcode and operands taken from the microcode for (op, pass). Go to CAPTURE.
- **CAPTURE:** `alu_enable=0`. Latch `alu_out` into temp register `t`.
  - If this was the last pass, compute the final result and go to RESP.
  - Otherwise increment pass and go to ISSUE.
- **RESP:** `resp_valid=1`. `resp_data` and `resp_illegal` stay stable until `resp_valid&&resp_ready`, then go to IDLE. `req_ready=0` everywhere outside IDLE.
- **Microcode:**
  - NOT, AND, ANDI, OR, XOR, ADD, ADDI: one pass with (op, a, b); result is `t`.
  - SUB: three passes, then result is `t`.
    - p0 NOT(b) gives t.
    - p1 ADD(t, 1) gives t.
    - p2 ADD(a, t) gives t.
    - The ALU drops the carry, so the result wraps modulo 2^WORD_SIZE.
  - LT (unsigned): the same three passes as SUB. Result is zero-extended:
    - if `a[MSB]!=b[MSB]`, result = `b[MSB]`;
    - otherwise, result = `t[MSB]`.
  - EQ, COMP: one pass XOR(a, b). Result is `{0…, t==0}`.
- **Pass separation:** `alu_enable` must drop for at least one cycle between passes. The gate counter counts on the enable's rising edge, so each pass must produce its own edge.
- **Reset** (any state, including mid-sequence):
  - Next state is IDLE.
  - `resp_valid=0`, `resp_illegal=0`, `resp_data=0`, `alu_enable=0`, `alu_opcode=0`, `alu_in1=0`, `alu_in2=0`.
  - `req_ready=0` while `reset` is high.
  - The in-flight operation is discarded. Any stale `alu_out` is ignored.

## Timing
- Request accepted at edge 0.
- Single-pass ops: ISSUE in cycle 1, CAPTURE in cycle 2, `resp_valid` in cycle 3.
- SUB and LT: `resp_valid` in cycle 7.
- Illegal opcode: `resp_valid` in cycle 1.
- With `resp_ready` held high, the earliest next accept is the cycle after the response handshake.
- All sequencer outputs are registered or decoded from state only. There is no combinational path from `req_*` or `resp_ready` to any output.

## Configuration
- `ALU_SEQ_STATS_EN`
  - **Defined:** adds outputs `stat_ops[31:0]` and `stat_passes[31:0]`.
    - `stat_ops` increments on each response handshake.
    - `stat_passes` increments on each ISSUE cycle.
    - Both wrap at 2^32 and clear on `reset`.
  - **Undefined:** the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- `parameters.vh` holds WORD_SIZE, OPCODE_SIZE and the opcode macros. Add to it the state encodings (`SEQ_IDLE`, `SEQ_ISSUE`, `SEQ_CAPTURE`, `SEQ_RESP`) and `SEQ_MAX_PASSES=3`.
- One combinational sub-module, `alu_seq_microcode`:
  - inputs: op, pass;
  - outputs: alu opcode, in1 select (a/b/t), in2 select (b/t/one), last flag, legal flag.

## Test plan
- ADD 0x1234 + 0x0FFF: `resp_data=0x2233` in cycle 3; one `alu_enable` pulse; counter deltas XOR+32, AND+32, OR+16.
- SUB 0x0005 − 0x0007: `0xFFFE` in cycle 7; three enable pulses, each separated by a low cycle; ALU opcodes NOT, ADD, ADD.
- LT operands and required results:
  - (0x0001, 0xFFFF) gives 1;
  - (0x8000, 0x7FFF) gives 0;
  - (0x7FFF, 0x8000) gives 1;
  - (0x1234, 0x1234) gives 0.
- EQ (0xABCD, 0xABCD) gives 0x0001; COMP (0xABCD, 0xABCC) gives 0x0000.
- Backpressure and illegal opcode: hold `resp_ready=0` for 5 cycles; `resp_data` stays stable and `req_ready=0` throughout. An illegal opcode then gives `resp_illegal=1`, data 0, and no enable pulse.
- Reset asserted in pass 1 of SUB: the following cycle is IDLE with `alu_enable=0` and `resp_valid=0`; stats are 0 when `ALU_SEQ_STATS_EN` is defined.
